// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: stall/bubble strobes for F/D/E/M/W, sticky HALT on a retired
// non-AOK status, and saturating hazard event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W    = 32,
    parameter logic [3:0]  REG_NONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_mispred,
    output logic [CNT_W-1:0] cnt_ret
);

    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] IOpq    = 4'h6;
    localparam logic [3:0] IJxx    = 4'h7;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPopq   = 4'hB;
    localparam logic [1:0] StatAok = 2'b00;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {StRun = 1'b0, StHalt = 1'b1} state_e;

    state_e r_state;
    state_e w_state_next;

    logic w_lu;
    logic w_mp;
    logic w_rt;
    logic w_exc;
    logic w_ret_bubble;

    logic [CNT_W-1:0] r_cnt_stall;
    logic [CNT_W-1:0] r_cnt_mispred;
    logic [CNT_W-1:0] r_cnt_ret;

    assign w_lu  = ((E_icode == IMrmovq) || (E_icode == IPopq)) && (E_dstM != REG_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_mp  = (E_icode == IJxx) && !e_Cnd;
    assign w_rt  = (D_icode == IRet) || (E_icode == IRet) || (M_icode == IRet);
    assign w_exc = (m_stat != StatAok) || (W_stat != StatAok);
    // A load/use stall holds D, so the ret bubble is deferred until the stall clears
    assign w_ret_bubble = !w_lu && w_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        F_stall      = w_lu || w_rt;
        D_stall      = w_lu;
        D_bubble     = w_mp || w_ret_bubble;
        E_bubble     = w_mp || w_lu;
        M_bubble     = w_exc;
        W_stall      = (W_stat != StatAok);
        set_cc       = (E_icode == IOpq) && !w_exc;
        if (r_state == StHalt) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
            set_cc   = 1'b0;
        end else if (W_stat != StatAok) begin
            w_state_next = StHalt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_stall   <= '0;
            r_cnt_mispred <= '0;
            r_cnt_ret     <= '0;
        end else if (r_state == StRun) begin
            if (w_lu && (r_cnt_stall != CntMax)) begin
                r_cnt_stall <= r_cnt_stall + CntOne;
            end
            if (w_mp && (r_cnt_mispred != CntMax)) begin
                r_cnt_mispred <= r_cnt_mispred + CntOne;
            end
            if (w_ret_bubble && (r_cnt_ret != CntMax)) begin
                r_cnt_ret <= r_cnt_ret + CntOne;
            end
        end
    end

    assign halted      = (r_state == StHalt);
    assign cnt_stall   = r_cnt_stall;
    assign cnt_mispred = r_cnt_mispred;
    assign cnt_ret     = r_cnt_ret;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors, a rule-level model checked every negedge,
// and literal expectations at key points. A CNT_W=4 copy exercises counter saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic       e_Cnd;
    logic [1:0] m_stat, W_stat;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [31:0] cnt_stall, cnt_mispred, cnt_ret;
    logic        F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4, set_cc4, halted4;
    logic [3:0]  cnt_stall4, cnt_mispred4, cnt_ret4;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic    m_halt;
    longint  m_stall, m_mispred, m_ret, m_stall4;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc(set_cc), .halted(halted), .cnt_stall(cnt_stall), .cnt_mispred(cnt_mispred),
        .cnt_ret(cnt_ret)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall4), .D_stall(D_stall4),
        .D_bubble(D_bubble4), .E_bubble(E_bubble4), .M_bubble(M_bubble4), .W_stall(W_stall4),
        .set_cc(set_cc4), .halted(halted4), .cnt_stall(cnt_stall4), .cnt_mispred(cnt_mispred4),
        .cnt_ret(cnt_ret4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit f_lu();
        return (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
    endfunction
    function automatic bit f_mp();
        return E_icode == 4'h7 && e_Cnd == 1'b0;
    endfunction
    function automatic bit f_rt();
        return D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    endfunction

    // Expected {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc,halted}
    function automatic logic [7:0] f_exp_strobes();
        bit lu, mp, rt, exc;
        if (m_halt) return 8'hFD;
        lu  = f_lu();
        mp  = f_mp();
        rt  = f_rt();
        exc = (m_stat != 2'd0) || (W_stat != 2'd0);
        return {lu || rt, lu, mp || (!lu && rt), mp || lu, exc, W_stat != 2'd0,
                E_icode == 4'h6 && !exc, 1'b0};
    endfunction

    function automatic longint sat(input longint v, input longint maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_halt    <= 1'b0;
            m_stall   <= 0;
            m_mispred <= 0;
            m_ret     <= 0;
            m_stall4  <= 0;
        end else if (!m_halt) begin
            if (W_stat != 2'd0) m_halt <= 1'b1;
            if (f_lu()) begin
                m_stall  <= sat(m_stall, 64'hFFFF_FFFF);
                m_stall4 <= sat(m_stall4, 15);
            end
            if (f_mp()) m_mispred <= sat(m_mispred, 64'hFFFF_FFFF);
            if (!f_lu() && f_rt()) m_ret <= sat(m_ret, 64'hFFFF_FFFF);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobes", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
                            halted}, f_exp_strobes());
            chk("strobes4", {F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4,
                             set_cc4, halted4}, f_exp_strobes());
            chk("cnt_stall", cnt_stall, m_stall);
            chk("cnt_mispred", cnt_mispred, m_mispred);
            chk("cnt_ret", cnt_ret, m_ret);
            chk("cnt_stall4", cnt_stall4, m_stall4);
        end
    end

    task automatic idle();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1; E_dstM = 4'hF;
        e_Cnd = 1'b1; M_icode = 4'h1; m_stat = 2'd0; W_stat = 2'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] strobes();
        return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted};
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        #1;
        chk("reset_halted", halted, 0);
        chk("reset_counters", {cnt_stall, cnt_mispred}, 0);
        chk("reset_cnt_ret", cnt_ret, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // load/use on srcA
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1 chk("lu_strobes", strobes(), 8'hD0);
        cyc();
        chk("lu_cnt", cnt_stall, 1);
        idle();

        // mispredicted jXX
        E_icode = 4'h7; e_Cnd = 1'b0;
        #1 chk("mp_strobes", strobes(), 8'h30);
        cyc();
        chk("mp_cnt", cnt_mispred, 1);
        idle();

        // ret walks D -> E -> M
        D_icode = 4'h9;
        #1 chk("ret_d", strobes(), 8'hA0);
        cyc(); D_icode = 4'h1; E_icode = 4'h9;
        #1 chk("ret_e", strobes(), 8'hA0);
        cyc(); E_icode = 4'h1; M_icode = 4'h9;
        #1 chk("ret_m", strobes(), 8'hA0);
        cyc();
        chk("ret_cnt", cnt_ret, 3);
        idle();

        // load/use on srcB beats ret in M
        E_icode = 4'h5; E_dstM = 4'h2; d_srcB = 4'h2; M_icode = 4'h9;
        #1 chk("lu_rt_strobes", strobes(), 8'hD0);
        cyc();
        chk("lu_rt_cnt", {cnt_stall, cnt_ret}, {32'd2, 32'd3});
        idle();

        // popq load/use, then dstM==REG_NONE must not match srcA==REG_NONE
        E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'h4;
        cyc();
        E_dstM = 4'hF; d_srcA = 4'hF;
        #1 chk("none_strobes", strobes(), 8'h00);
        cyc();
        chk("none_cnt", cnt_stall, 3);
        idle();

        // hold load/use 20 cycles: 4-bit copy saturates
        E_icode = 4'h5; E_dstM = 4'h7; d_srcA = 4'h7;
        repeat (20) cyc();
        chk("sat_cnt4", cnt_stall4, 4'hF);
        chk("sat_cnt32", cnt_stall, 23);
        idle();

        // set_cc with and without exception
        E_icode = 4'h6;
        #1 chk("opq_cc", strobes(), 8'h02);
        cyc();
        m_stat = 2'd2;
        #1 chk("exc_cc", strobes(), 8'h08);
        cyc();
        m_stat = 2'd0; E_icode = 4'h1; W_stat = 2'd2;
        #1 chk("wstat_run", strobes(), 8'h0C);
        cyc();
        W_stat = 2'd0;
        #1 chk("halt_entry", strobes(), 8'hFD);

        // frozen in HALT regardless of inputs
        for (int i = 0; i < 5; i++) begin
            if (i[0]) begin
                E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
            end else begin
                E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
            end
            cyc();
            chk("halt_strobes", strobes(), 8'hFD);
        end
        chk("halt_counters", {cnt_stall, cnt_mispred}, {32'd23, 32'd1});
        chk("halt_cnt_ret", cnt_ret, 3);
        idle();

        // asynchronous reset mid-HALT
        #2 rst_n = 1'b0;
        #1;
        chk("arst_halted", halted, 0);
        chk("arst_counters", {cnt_stall, cnt_mispred}, 0);
        chk("arst_cnt", {cnt_ret, cnt_stall4}, 0);
        chk("arst_strobes", strobes(), 8'h00);
        #8 rst_n = 1'b1;
        cyc();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        cyc();
        chk("resume_cnt", {halted, cnt_stall}, {1'b0, 32'd1});
        idle();
        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
